// File: rtl/apb_mem_slave_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_mem_slave_if : APB3/APB4 bus bundle for apb_mem_slave           |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface apb_mem_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/apb_mem_slave.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_mem_slave : APB slave memory, byte strobes, wait states, errors |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module apb_mem_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int DEPTH       = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic          pclk,
  input  logic          rst_n,
  apb_mem_slave_if.slave apb
);

  localparam int                C_STRB_W = DATA_W / 8;
  localparam int                C_IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   C_DEPTH  = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]        C_WAIT   = 4'(WAIT_STATES);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                addr_err;
  logic [C_IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0]   rd_word;

  // In-range addresses are below DEPTH, so dropping the upper bits is lossless.
  assign addr_err = ({1'b0, apb.paddr} >= C_DEPTH);
  assign mem_idx  = apb.paddr[C_IDX_W-1:0];
  assign rd_word  = mem_q[mem_idx];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    mem_we    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (apb.psel && !apb.penable) begin
          state_d = ST_ACCESS;
          err_d   = addr_err;
          cnt_d   = C_WAIT;
          if (WAIT_STATES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = addr_err;
            if (addr_err) begin
              prdata_d = '0;
            end else if (!apb.pwrite) begin
              prdata_d = rd_word;
            end
          end
        end
      end

      ST_ACCESS: begin
        if (!apb.psel) begin
          // Master abandoned the transfer: drop back without touching memory.
          state_d   = ST_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (pready_q) begin
          mem_we    = apb.pwrite && !err_q;
          state_d   = ST_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            if (err_q) begin
              prdata_d = '0;
            end else if (!apb.pwrite) begin
              prdata_d = rd_word;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Storage is not reset; reset only suppresses a write at its edge.
  always_ff @(posedge pclk) begin
    if (rst_n && mem_we) begin
      for (int i = 0; i < C_STRB_W; i++) begin
        if (apb.pstrb[i]) begin
          mem_q[mem_idx][8*i +: 8] <= apb.pwdata[8*i +: 8];
        end
      end
    end
  end

  assign apb.prdata  = prdata_q;
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_slave.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_apb_mem_slave : self-checking bench, WAIT_STATES = 0, 1 and 4    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_apb_mem_slave;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 12;
  localparam int NI    = 3;

  logic          pclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          b_psel, b_penable, b_pwrite;
  logic [AW-1:0] b_paddr;
  logic [DW-1:0] b_pwdata;
  logic [3:0]    b_pstrb;
  int            sel;
  logic [DW-1:0] m_prdata;
  logic          m_pready, m_pslverr;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem [NI][16];
  logic [31:0] ref_rd  [NI];

  always #5 pclk = ~pclk;

  apb_mem_slave_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  apb_mem_slave_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
  apb_mem_slave_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

  assign bus0.psel = b_psel && (sel == 0);
  assign bus1.psel = b_psel && (sel == 1);
  assign bus2.psel = b_psel && (sel == 2);
  assign bus0.penable = b_penable;  assign bus1.penable = b_penable;  assign bus2.penable = b_penable;
  assign bus0.pwrite  = b_pwrite;   assign bus1.pwrite  = b_pwrite;   assign bus2.pwrite  = b_pwrite;
  assign bus0.paddr   = b_paddr;    assign bus1.paddr   = b_paddr;    assign bus2.paddr   = b_paddr;
  assign bus0.pwdata  = b_pwdata;   assign bus1.pwdata  = b_pwdata;   assign bus2.pwdata  = b_pwdata;
  assign bus0.pstrb   = b_pstrb;    assign bus1.pstrb   = b_pstrb;    assign bus2.pstrb   = b_pstrb;

  apb_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut_ws0 (
    .pclk(pclk), .rst_n(rst_n), .apb(bus0.slave));
  apb_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(1)) u_dut_ws1 (
    .pclk(pclk), .rst_n(rst_n), .apb(bus1.slave));
  apb_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(4)) u_dut_ws4 (
    .pclk(pclk), .rst_n(rst_n), .apb(bus2.slave));

  always_comb begin
    m_prdata  = bus1.prdata;
    m_pready  = bus1.pready;
    m_pslverr = bus1.pslverr;
    case (sel)
      0: begin m_prdata = bus0.prdata; m_pready = bus0.pready; m_pslverr = bus0.pslverr; end
      2: begin m_prdata = bus2.prdata; m_pready = bus2.pready; m_pslverr = bus2.pslverr; end
      default: ;
    endcase
  end

  function automatic int ws_of(input int inst);
    case (inst)
      0:       return 0;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: word array, out-of-range => error with zero data, prdata held on writes.
  task automatic model_xfer(input int inst, input logic [3:0] addr, input logic wr,
                            input logic [31:0] wd, input logic [3:0] st,
                            output logic [31:0] exp_rd, output logic exp_err);
    exp_err = (int'(addr) >= DEPTH);
    if (exp_err) ref_rd[inst] = 32'h0;
    else if (!wr) ref_rd[inst] = ref_mem[inst][addr];
    if (wr && !exp_err)
      for (int i = 0; i < 4; i++)
        if (st[i]) ref_mem[inst][addr][8*i +: 8] = wd[8*i +: 8];
    exp_rd = ref_rd[inst];
  endtask

  // Starts at posedge+1; returns at posedge+1 just after the completion edge.
  task automatic do_xfer(input logic [3:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] st, output logic [31:0] rd, output logic err,
                         output int cycles);
    bit got = 0;
    b_psel = 1'b1; b_penable = 1'b0; b_pwrite = wr;
    b_paddr = addr; b_pwdata = wd; b_pstrb = st;
    @(posedge pclk); #1;
    b_penable = 1'b1;
    cycles = 2;
    for (int k = 0; k < 40; k++) begin
      @(negedge pclk);
      if (m_pready) begin got = 1; break; end
      @(posedge pclk); #1;
      cycles++;
    end
    rd  = m_prdata;
    err = m_pslverr;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL pready_timeout actual=0 required=1");
      b_psel = 1'b0; b_penable = 1'b0;
    end
    @(posedge pclk); #1;
  endtask

  task automatic idle(input int n);
    b_psel = 1'b0; b_penable = 1'b0;
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  task automatic run_checked(input int inst, input logic [3:0] addr, input logic wr,
                             input logic [31:0] wd, input logic [3:0] st, input string name);
    logic [31:0] rd, exp_rd;
    logic        err, exp_err;
    int          cyc;
    do_xfer(addr, wr, wd, st, rd, err, cyc);
    model_xfer(inst, addr, wr, wd, st, exp_rd, exp_err);
    check($sformatf("%s_prdata", name), rd, exp_rd);
    check($sformatf("%s_pslverr", name), {31'b0, err}, {31'b0, exp_err});
    check($sformatf("%s_cycles", name), 32'(cyc), 32'(2 + ws_of(inst)));
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, exp_rd;
    logic        err, exp_err;
    int          cyc;
    time         t0;

    vecs[0] = '{4'd3,  1'b1, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1] = '{4'd3,  1'b0, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{4'd3,  1'b1, 32'h11223344, 4'h5, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{4'd3,  1'b0, 32'h0,        4'h0, 32'hDE22BE44, 1'b0};
    vecs[4] = '{4'd13, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[5] = '{4'd12, 1'b0, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[6] = '{4'd3,  1'b0, 32'h0,        4'hF, 32'hDE22BE44, 1'b0};

    for (int i = 0; i < NI; i++) begin
      ref_rd[i] = 32'h0;
      for (int a = 0; a < 16; a++) ref_mem[i][a] = 32'h0;
    end

    // Reset held for two edges with a write attempt on the bus.
    sel = 1;
    b_psel = 1'b1; b_penable = 1'b0; b_pwrite = 1'b1;
    b_paddr = 4'd3; b_pwdata = 32'hCAFEF00D; b_pstrb = 4'hF;
    @(posedge pclk); #1;
    b_penable = 1'b1;
    @(posedge pclk); #1;
    for (int i = 0; i < NI; i++) begin
      sel = i;
      #1;
      check($sformatf("reset_pready_%0d", i), {31'b0, m_pready}, 32'h0);
      check($sformatf("reset_pslverr_%0d", i), {31'b0, m_pslverr}, 32'h0);
      check($sformatf("reset_prdata_%0d", i), m_prdata, 32'h0);
    end
    sel = 1;
    rst_n = 1'b1;
    idle(1);

    // Directed vectors on the WAIT_STATES=1 instance.
    for (int v = 0; v < 7; v++) begin
      do_xfer(vecs[v].addr, vecs[v].wr, vecs[v].wd, vecs[v].st, rd, err, cyc);
      model_xfer(1, vecs[v].addr, vecs[v].wr, vecs[v].wd, vecs[v].st, exp_rd, exp_err);
      check($sformatf("vec%0d_prdata", v), rd, vecs[v].exp_rd);
      check($sformatf("vec%0d_pslverr", v), {31'b0, err}, {31'b0, vecs[v].exp_err});
      check($sformatf("vec%0d_cycles", v), 32'(cyc), 32'd3);
    end

    // Abort: psel dropped during the wait cycle of a write to addr 5.
    run_checked(1, 4'd5, 1'b1, 32'hA5A5A5A5, 4'hF, "pre_abort_wr");
    b_psel = 1'b1; b_penable = 1'b0; b_pwrite = 1'b1;
    b_paddr = 4'd5; b_pwdata = 32'h12345678; b_pstrb = 4'hF;
    @(posedge pclk); #1;
    b_psel = 1'b0; b_penable = 1'b0;
    @(negedge pclk);
    check("abort_wait_pready", {31'b0, m_pready}, 32'h0);
    @(posedge pclk); #1;
    @(negedge pclk);
    check("abort_after_pready", {31'b0, m_pready}, 32'h0);
    @(posedge pclk); #1;
    run_checked(1, 4'd5, 1'b0, 32'h0, 4'h0, "post_abort_rd");

    // Reset asserted in the completion cycle of a write to addr 5.
    b_psel = 1'b1; b_penable = 1'b0; b_pwrite = 1'b1;
    b_paddr = 4'd5; b_pwdata = 32'hFFFF0000; b_pstrb = 4'hF;
    @(posedge pclk); #1;
    b_penable = 1'b1;
    @(posedge pclk); #1;
    rst_n = 1'b0;
    @(negedge pclk);
    check("midrst_pre_pready", {31'b0, m_pready}, 32'h1);
    @(posedge pclk); #1;
    rst_n = 1'b1;
    b_psel = 1'b0; b_penable = 1'b0;
    @(negedge pclk);
    check("midrst_pready", {31'b0, m_pready}, 32'h0);
    check("midrst_pslverr", {31'b0, m_pslverr}, 32'h0);
    check("midrst_prdata", m_prdata, 32'h0);
    for (int i = 0; i < NI; i++) ref_rd[i] = 32'h0;
    @(posedge pclk); #1;
    run_checked(1, 4'd5, 1'b0, 32'h0, 4'h0, "midrst_rd5");
    idle(1);

    // Back-to-back write/read/write on the 0- and 4-wait-state builds.
    for (int inst = 0; inst < NI; inst += 2) begin
      sel = inst;
      idle(1);
      t0 = $time;
      run_checked(inst, 4'd0, 1'b1, $urandom, 4'hF, $sformatf("b2b%0d_w0", inst));
      run_checked(inst, 4'd0, 1'b0, 32'h0,    4'h0, $sformatf("b2b%0d_r0", inst));
      run_checked(inst, 4'd1, 1'b1, $urandom, 4'hF, $sformatf("b2b%0d_w1", inst));
      check($sformatf("b2b%0d_total", inst), 32'(($time - t0) / 10), 32'(3 * (2 + ws_of(inst))));
      idle(1);
    end

    // Randomised traffic against the reference on all three builds.
    for (int inst = 0; inst < NI; inst++) begin
      sel = inst;
      idle(1);
      for (int a = 0; a < DEPTH; a++)
        run_checked(inst, 4'(a), 1'b1, $urandom, 4'hF, $sformatf("init%0d_%0d", inst, a));
      for (int n = 0; n < 40; n++) begin
        run_checked(inst, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    $urandom, 4'($urandom_range(0, 15)), $sformatf("rnd%0d_%0d", inst, n));
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
      idle(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
